wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Synthesizable writeback trace capture for the pipelined CPU.
- Records the writeback stream (PC plus result) of retiring instructions into a circular buffer, stamping each entry with a sequence number.
- Optionally filters zero results, which are NOP bubbles.
- Exposes entries through a first-word-fall-through valid/ready read port, plus event and drop counters.
- Replaces ad-hoc printing of every nonzero result with a parametrised, lossless-or-ring capture unit usable in simulation and on FPGA.

Parameters:
- DATA_W, 32, width of the writeback result.
- ADDR_W, 32, width of the PC.
- DEPTH, 16, buffer entries; power of two, at least 2.
- CNT_W, 16, width of the sequence, event and drop counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of buffer and counters.
- en  in  1  capture enable.
- filter_zero  in  1  1 = ignore events whose wb_result == 0.
- ring_mode  in  1  1 = overwrite oldest when full; 0 = stop and drop new.
- wb_valid  in  1  writeback event present this cycle.
- wb_pc  in  ADDR_W  PC associated with the event.
- wb_result  in  DATA_W  writeback value.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry available; equals !empty.
- rd_pc  out  ADDR_W  head entry PC.
- rd_result  out  DATA_W  head entry result.
- rd_seq  out  CNT_W  head entry sequence number.
- count  out  $clog2(DEPTH)+1  entries held.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- event_cnt  out  CNT_W  eligible events seen; wraps.
- drop_cnt  out  CNT_W  events lost; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): head, tail, count, event_cnt and drop_cnt = 0; empty=1, full=0, rd_valid=0. rd_pc, rd_result and rd_seq are don't-care while rd_valid=0; the bench checks them only when rd_valid=1.
- Eligible event: `en & wb_valid & !(filter_zero & (wb_result == 0))`. Each eligible event increments event_cnt.
- Entry seq field = event_cnt value before the increment. The first eligible event after reset or clear gets seq 0.
- Pop: `rd_valid & rd_ready`. Head advances modulo DEPTH.
- FWFT read: rd_* show mem[head] combinationally from registered state. No pop occurs when empty.
- Latency: an event sampled at edge N is visible on rd_valid/rd_* after edge N, i.e. 1 cycle.
- Push, not full: write mem[tail], tail+1, count+1.
- Push + pop, same cycle, any fill level: both occur and count is unchanged. This includes full in either mode, where no drop occurs, and count==1, where the new entry becomes head next cycle.
- Push, full, no pop, ring_mode=1: overwrite mem[tail]; head and tail both advance; count stays DEPTH; drop_cnt+1 (the oldest entry is lost).
- Push, full, no pop, ring_mode=0: new event discarded; pointers unchanged; drop_cnt+1.
- Ineligible events (en=0, wb_valid=0, or filtered zero): no state change at all, including counters.
- drop_cnt saturates and does not wrap. event_cnt and seq wrap modulo 2^CNT_W.
- Pointer wrap: head and tail are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer equality.
- clear=1: same end state as reset at the next edge. Takes priority over push and pop in that cycle; an event in that cycle is neither stored nor counted.
- Mode inputs may change on any cycle and take effect on the same edge. The buffer contents are unaffected by a mode change.
- Reset asserted mid-operation: immediate clear, independent of clk. Contents are discarded.

Test Plan:
- Reset, then push 3 events (pc 0x0/0x4/0x8, results 5/7/9), rd_ready=0 -> count=3; head rd_pc=0x0, rd_result=5, rd_seq=0. Then rd_ready=1 for 3 cycles -> pops in order, empty=1.
- filter_zero=1, results 0,3,0,4 on consecutive cycles -> count=2, event_cnt=2, entries (3,seq0),(4,seq1). filter_zero=0, same stimulus -> count=4, event_cnt=4.
- ring_mode=0, DEPTH=16, push 20 events with results 1..20, no reads -> full=1, drop_cnt=4, read order 1..16.
- ring_mode=1, same stimulus -> drop_cnt=4, read order 5..20, rd_seq 4..19.
- Full buffer, push and pop on the same cycle -> count stays 16, drop_cnt unchanged, new entry appears at the tail.
- Assert rst asynchronously mid-stream, then assert clear while wb_valid=1 -> count=0 and counters=0 immediately on rst. No capture in the clear cycle; the next event gets seq 0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular capture of the writeback stream with FWFT read port and event/drop counters
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       filter_zero,
  input  logic                       ring_mode,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_pc,
  input  logic [DATA_W-1:0]          wb_result,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_result,
  output logic [CNT_W-1:0]           rd_seq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           event_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] mem_pc  [DEPTH];
  logic [DATA_W-1:0] mem_res [DEPTH];
  logic [CNT_W-1:0]  mem_seq [DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop, wr, adv_head, drop, inc, dec;
  always_comb begin
    push     = en & wb_valid & ~(filter_zero & (wb_result == '0));
    pop      = ~empty & rd_ready;
    wr       = push & (pop | ~full | ring_mode);
    drop     = push & full & ~pop;
    adv_head = pop | (drop & ring_mode);
    inc      = push & ~pop & ~full;
    dec      = pop & ~push;
  end
  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign rd_valid  = ~empty;
  assign rd_pc     = mem_pc[head];
  assign rd_result = mem_res[head];
  assign rd_seq    = mem_seq[head];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      event_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      event_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (wr) tail <= tail + PW'(1);
      if (adv_head) head <= head + PW'(1);
      count <= inc ? count + CW'(1) : dec ? count - CW'(1) : count;
      if (push) event_cnt <= event_cnt + CNT_W'(1);
      if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk)
    if (wr && !clear && !rst) begin
      mem_pc[tail]  <= wb_pc;
      mem_res[tail] <= wb_result;
      mem_seq[tail] <= event_cnt;
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed checks of capture, filtering, lossless/ring overflow, clear and async reset
module tb_wb_trace_buffer;
  logic clk = 0, rst = 1, clear = 0, en = 1, filter_zero = 0, ring_mode = 0;
  logic wb_valid = 0, rd_ready = 0;
  logic [31:0] wb_pc = 0, wb_result = 0;
  logic rd_valid, full, empty;
  logic [31:0] rd_pc, rd_result;
  logic [15:0] rd_seq, event_cnt, drop_cnt;
  logic [4:0] count;
  int checks = 0, failures = 0;

  wb_trace_buffer dut (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .filter_zero(filter_zero),
    .ring_mode(ring_mode), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_result(wb_result),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_result(rd_result),
    .rd_seq(rd_seq), .count(count), .full(full), .empty(empty),
    .event_cnt(event_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] res);
    wb_valid = 1; wb_pc = pc; wb_result = res; rd_ready = 0;
    step();
    wb_valid = 0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] res, input logic [15:0] seq);
    wb_valid = 0; rd_ready = 1;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_res"}, rd_result, res);
    chk({tag, "_seq"}, rd_seq, seq);
    step();
    rd_ready = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  initial begin
    #12 rst = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_event", event_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    step();

    push(32'h0, 5); push(32'h4, 7); push(32'h8, 9);
    chk("b_count", count, 3);
    chk("b_pc0", rd_pc, 32'h0);
    pop_chk("b0", 5, 0);
    chk("b_pc1", rd_pc, 32'h4);
    pop_chk("b1", 7, 1);
    chk("b_pc2", rd_pc, 32'h8);
    pop_chk("b2", 9, 2);
    chk("b_empty", empty, 1);
    chk("b_noval", rd_valid, 0);

    do_clear();
    filter_zero = 1;
    push(32'h10, 0); push(32'h14, 3); push(32'h18, 0); push(32'h1c, 4);
    chk("f_count", count, 2);
    chk("f_event", event_cnt, 2);
    pop_chk("f0", 3, 0);
    pop_chk("f1", 4, 1);
    do_clear();
    filter_zero = 0;
    push(32'h10, 0); push(32'h14, 3); push(32'h18, 0); push(32'h1c, 4);
    chk("nf_count", count, 4);
    chk("nf_event", event_cnt, 4);
    chk("nf_head", rd_result, 0);

    do_clear();
    ring_mode = 0;
    for (int i = 1; i <= 20; i++) push(i * 4, i);
    chk("l_full", full, 1);
    chk("l_count", count, 16);
    chk("l_drop", drop_cnt, 4);
    chk("l_event", event_cnt, 20);
    for (int i = 1; i <= 16; i++) pop_chk("l_rd", i, 16'(i - 1));
    chk("l_empty", empty, 1);

    do_clear();
    ring_mode = 1;
    for (int i = 1; i <= 20; i++) push(i * 4, i);
    chk("r_full", full, 1);
    chk("r_drop", drop_cnt, 4);
    chk("r_event", event_cnt, 20);
    wb_valid = 1; wb_pc = 32'h190; wb_result = 100; rd_ready = 1;
    chk("pp_head", rd_result, 5);
    step();
    wb_valid = 0; rd_ready = 0;
    chk("pp_count", count, 16);
    chk("pp_drop", drop_cnt, 4);
    for (int i = 6; i <= 20; i++) pop_chk("r_rd", i, 16'(i - 1));
    pop_chk("pp_new", 100, 20);
    chk("r_empty", empty, 1);

    do_clear();
    ring_mode = 0;
    push(32'h20, 11); push(32'h24, 12);
    #3 rst = 1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_event", event_cnt, 0);
    chk("ar_empty", empty, 1);
    #2 rst = 0;
    step();
    clear = 1; wb_valid = 1; wb_pc = 32'h30; wb_result = 33;
    step();
    clear = 0; wb_valid = 0;
    chk("cl_count", count, 0);
    chk("cl_event", event_cnt, 0);
    push(32'h34, 44);
    chk("cl_count1", count, 1);
    chk("cl_pc", rd_pc, 32'h34);
    pop_chk("cl_seq", 44, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
